fetch_ctrl: RTL and testbench

Instruction-fetch sequencer between the PC/instruction-ROM path and the decode stage. It owns the fetch address and issues requests to a variable-latency instruction ROM through a req/ack handshake. It arbitrates the next fetch address between reset, exception, branch and sequential (pc+4) sources, and presents fetched instructions to decode through a one-entry output slot backed by a one-entry skid buffer.

---
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_fetch_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: ROM request/ack, decode output slot and redirect inputs.
interface fetch_ctrl_if;
   logic        exc_ce;
   logic        j_ce;
   logic [31:0] j_addr;
   logic        stall;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic        rom_ack;
   logic [31:0] rom_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   // Fetch controller side
   modport master (
      input  exc_ce, j_ce, j_addr, stall, rom_ack, rom_data,
      output rom_ce, rom_addr, inst_valid, inst, inst_pc
   );

   // Environment side (ROM, decode, redirect sources)
   modport slave (
      output exc_ce, j_ce, j_addr, stall, rom_ack, rom_data,
      input  rom_ce, rom_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch pc, issues one outstanding ROM request at a
// time, and hands instructions to decode through a one-entry slot plus one-entry skid buffer.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_0020
) (
   input logic          clk,
   input logic          rst,
   fetch_ctrl_if.master bus
);

   typedef enum logic [1:0] {StReset, StReq, StSkid} state_e;

   state_e      r_state, w_state_d;
   logic [31:0] r_pc, w_pc_d;
   logic        r_inst_valid, w_inst_valid_d;
   logic [31:0] r_inst, w_inst_d;
   logic [31:0] r_inst_pc, w_inst_pc_d;
   logic        r_s_valid, w_s_valid_d;
   logic [31:0] r_s_inst, w_s_inst_d;
   logic [31:0] r_s_pc, w_s_pc_d;
   logic        r_discard, w_discard_d;
   logic [31:0] r_redir_addr, w_redir_addr_d;

   logic        w_redir;
   logic [31:0] w_target;
   logic        w_consume;

   assign w_redir   = bus.exc_ce | bus.j_ce;
   assign w_target  = bus.exc_ce ? EXC_VEC : bus.j_addr;
   assign w_consume = r_inst_valid & ~bus.stall;

   // Next-state: fetch arbitration, slot/skid movement and redirect handling
   always_comb begin
      w_state_d      = r_state;
      w_pc_d         = r_pc;
      w_inst_valid_d = r_inst_valid;
      w_inst_d       = r_inst;
      w_inst_pc_d    = r_inst_pc;
      w_s_valid_d    = r_s_valid;
      w_s_inst_d     = r_s_inst;
      w_s_pc_d       = r_s_pc;
      w_discard_d    = r_discard;
      w_redir_addr_d = r_redir_addr;

      if (w_consume) begin
         w_inst_valid_d = 1'b0;
      end

      unique case (r_state)
         StReset: begin
            w_state_d = StReq;
            w_pc_d    = w_redir ? w_target : RESET_PC;
         end
         StReq: begin
            if (!bus.rom_ack) begin
               // Request in flight: address must hold, so remember where to go after the ack
               if (w_redir) begin
                  w_discard_d    = 1'b1;
                  w_redir_addr_d = w_target;
               end
            end else if (w_redir) begin
               w_pc_d      = w_target;
               w_discard_d = 1'b0;
            end else if (r_discard) begin
               w_pc_d      = r_redir_addr;
               w_discard_d = 1'b0;
            end else if (!r_inst_valid || !bus.stall) begin
               w_inst_valid_d = 1'b1;
               w_inst_d       = bus.rom_data;
               w_inst_pc_d    = r_pc;
               w_pc_d         = r_pc + 32'd4;
            end else begin
               w_s_valid_d = 1'b1;
               w_s_inst_d  = bus.rom_data;
               w_s_pc_d    = r_pc;
               w_pc_d      = r_pc + 32'd4;
               w_state_d   = StSkid;
            end
         end
         StSkid: begin
            if (w_redir) begin
               w_pc_d    = w_target;
               w_state_d = StReq;
            end else if (w_consume) begin
               w_inst_valid_d = 1'b1;
               w_inst_d       = r_s_inst;
               w_inst_pc_d    = r_s_pc;
               w_s_valid_d    = 1'b0;
               w_state_d      = StReq;
            end
         end
         default: begin
            w_state_d = StReset;
         end
      endcase

      // Anything fetched before a redirect must never reach decode
      if (w_redir) begin
         w_inst_valid_d = 1'b0;
         w_s_valid_d    = 1'b0;
      end
   end

   // State register with asynchronous reset; abandons any outstanding request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StReset;
         r_pc         <= RESET_PC;
         r_inst_valid <= 1'b0;
         r_inst       <= 32'h0;
         r_inst_pc    <= 32'h0;
         r_s_valid    <= 1'b0;
         r_s_inst     <= 32'h0;
         r_s_pc       <= 32'h0;
         r_discard    <= 1'b0;
         r_redir_addr <= 32'h0;
      end else begin
         r_state      <= w_state_d;
         r_pc         <= w_pc_d;
         r_inst_valid <= w_inst_valid_d;
         r_inst       <= w_inst_d;
         r_inst_pc    <= w_inst_pc_d;
         r_s_valid    <= w_s_valid_d;
         r_s_inst     <= w_s_inst_d;
         r_s_pc       <= w_s_pc_d;
         r_discard    <= w_discard_d;
         r_redir_addr <= w_redir_addr_d;
      end
   end

   assign bus.rom_ce     = (r_state == StReq);
   assign bus.rom_addr   = r_pc;
   assign bus.inst_valid = r_inst_valid;
   assign bus.inst       = r_inst;
   assign bus.inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a scripted cycle-accurate stimulus pushes the pcs that
// decode should receive; a monitor pops and compares every consumed instruction.
module tb_fetch_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_ctrl_if bus ();

   fetch_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int waits   = 0;
   int rom_cnt = 0;
   logic [31:0] exp_q[$];

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // ROM model with a configurable number of wait states
   always @(posedge clk) begin
      if (!bus.rom_ce || bus.rom_ack) rom_cnt <= 0;
      else rom_cnt <= rom_cnt + 1;
   end

   always_comb begin
      bus.rom_ack  = bus.rom_ce && (rom_cnt == waits);
      bus.rom_data = bus.rom_ack ? rom_word(bus.rom_addr) : 32'h0;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare each instruction decode actually takes
   always @(negedge clk) begin
      if (!rst && bus.inst_valid && !bus.stall && !bus.exc_ce && !bus.j_ce) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL deliver: unexpected pc %h inst %h, queue empty", bus.inst_pc,
                     bus.inst);
         end else begin
            logic [31:0] e_pc;
            e_pc = exp_q.pop_front();
            if (bus.inst_pc !== e_pc || bus.inst !== rom_word(e_pc)) begin
               n_fail++;
               $display("FAIL deliver: got pc %h inst %h, expected pc %h inst %h",
                        bus.inst_pc, bus.inst, e_pc, rom_word(e_pc));
            end
         end
      end
   end

   // romAddr must not move while a request waits for its ack
   logic        p_ok = 1'b0;
   logic [31:0] p_addr = 32'h0;
   always @(negedge clk) begin
      if (!rst && p_ok && bus.rom_ce) begin
         n_tests++;
         if (bus.rom_addr !== p_addr) begin
            n_fail++;
            $display("FAIL addr_stable: got %h, expected %h", bus.rom_addr, p_addr);
         end
      end
      p_ok   <= !rst && bus.rom_ce && !bus.rom_ack;
      p_addr <= bus.rom_addr;
   end

   int cyc = 0;
   task automatic next_cyc();
      @(posedge clk);
      #1;
      cyc++;
   endtask
   task automatic go(input int n);
      while (cyc < n) next_cyc();
   endtask

   initial begin
      bus.exc_ce = 1'b0;
      bus.j_ce   = 1'b0;
      bus.j_addr = 32'h0;
      bus.stall  = 1'b0;
      #1;
      chk("rst_rom_ce", {31'b0, bus.rom_ce}, 32'h0);
      chk("rst_rom_addr", bus.rom_addr, 32'h0);
      chk("rst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      chk("rst_inst", bus.inst, 32'h0);
      chk("rst_inst_pc", bus.inst_pc, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      // Zero-wait ROM: back-to-back fetch, then stall into the skid buffer
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      exp_q.push_back(32'hC);
      exp_q.push_back(32'h10);
      exp_q.push_back(32'h14);
      chk("c0_rom_ce", {31'b0, bus.rom_ce}, 32'h0);
      go(1);
      chk("c1_rom_addr", bus.rom_addr, 32'h0);
      chk("c1_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      go(2);
      chk("c2_rom_addr", bus.rom_addr, 32'h4);
      go(3);
      chk("c3_rom_addr", bus.rom_addr, 32'h8);
      chk("c3_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
      go(4);
      chk("c4_rom_addr", bus.rom_addr, 32'hC);
      bus.stall = 1'b1;
      go(5);
      chk("skid_rom_ce", {31'b0, bus.rom_ce}, 32'h0);
      chk("skid_slot_hold", bus.inst_pc, 32'h8);
      go(6);
      chk("skid_rom_addr", bus.rom_addr, 32'h10);
      go(7);
      bus.stall = 1'b0;
      waits = 2;
      go(8);
      chk("skid_drain_pc", bus.inst_pc, 32'hC);
      chk("c8_rom_addr", bus.rom_addr, 32'h10);
      // Two wait states: address held three cycles, slot pulses once per fetch
      go(9);
      chk("w9_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      go(10);
      chk("w10_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      go(11);
      chk("w11_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
      chk("w11_rom_addr", bus.rom_addr, 32'h14);
      // Branch during a wait on 0x18: stale ack dropped, fetch resumes at 0x100
      exp_q.push_back(32'h100);
      go(15);
      chk("j15_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      bus.j_ce   = 1'b1;
      bus.j_addr = 32'h100;
      go(16);
      bus.j_ce = 1'b0;
      chk("j16_rom_addr", bus.rom_addr, 32'h18);
      go(17);
      chk("j17_rom_addr", bus.rom_addr, 32'h100);
      chk("j17_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      go(20);
      chk("j20_inst_pc", bus.inst_pc, 32'h100);
      // Exception and branch together: exception vector wins
      exp_q.push_back(32'h20);
      go(21);
      bus.exc_ce = 1'b1;
      bus.j_ce   = 1'b1;
      bus.j_addr = 32'h200;
      go(22);
      bus.exc_ce = 1'b0;
      bus.j_ce   = 1'b0;
      go(23);
      chk("exc_rom_addr", bus.rom_addr, 32'h20);
      go(26);
      chk("exc_inst_pc", bus.inst_pc, 32'h20);
      // Branch to the top word: pc+4 wraps to zero
      go(27);
      bus.j_ce   = 1'b1;
      bus.j_addr = 32'hFFFF_FFFC;
      go(28);
      bus.j_ce = 1'b0;
      go(29);
      chk("wrap_top_addr", bus.rom_addr, 32'hFFFF_FFFC);
      go(32);
      chk("wrap_rom_addr", bus.rom_addr, 32'h0);
      bus.stall = 1'b1;
      go(33);
      chk("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
      // Reset mid-wait takes effect without a clock edge
      rst = 1'b1;
      #1;
      chk("arst_rom_ce", {31'b0, bus.rom_ce}, 32'h0);
      chk("arst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      bus.stall = 1'b0;
      go(34);
      rst = 1'b0;
      chk("rel_rom_ce", {31'b0, bus.rom_ce}, 32'h0);
      exp_q.push_back(32'h0);
      go(35);
      chk("rel_rom_addr", bus.rom_addr, 32'h0);
      chk("rel_rom_ce1", {31'b0, bus.rom_ce}, 32'h1);
      // Stall released on the ack cycle with a full slot: consume and refill, no skid
      go(38);
      bus.stall = 1'b1;
      go(40);
      bus.stall = 1'b0;
      go(41);
      chk("refill_rom_ce", {31'b0, bus.rom_ce}, 32'h1);
      chk("refill_inst_pc", bus.inst_pc, 32'h4);
      chk("refill_rom_addr", bus.rom_addr, 32'h8);
      bus.stall = 1'b1;
      // Redirect from the skid state: both entries flushed, request at the next cycle
      go(44);
      chk("skid2_rom_ce", {31'b0, bus.rom_ce}, 32'h0);
      chk("skid2_rom_addr", bus.rom_addr, 32'hC);
      bus.j_ce   = 1'b1;
      bus.j_addr = 32'h300;
      exp_q.push_back(32'h300);
      go(45);
      bus.j_ce  = 1'b0;
      bus.stall = 1'b0;
      chk("sredir_rom_addr", bus.rom_addr, 32'h300);
      chk("sredir_rom_ce", {31'b0, bus.rom_ce}, 32'h1);
      chk("sredir_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
      go(48);
      chk("sredir_inst_pc", bus.inst_pc, 32'h300);
      go(49);
      bus.stall = 1'b1;
      go(53);
      chk("queue_empty", exp_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
